// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one multiplier between two requesters; an in-order
// tag FIFO routes results back. Define MULT_ARB_STATS_EN for per-requester grant counters.
module mult_arbiter #(
    parameter int DATA_W    = 32,
    parameter int TAG_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_r0_data,
    input  logic              i_r0_valid,
    output logic              o_r0_ready,
    input  logic [DATA_W-1:0] i_r1_data,
    input  logic              i_r1_valid,
    output logic              o_r1_ready,
    output logic [DATA_W-1:0] o_r0_res,
    output logic              o_r0_res_valid,
    input  logic              i_r0_res_ready,
    output logic [DATA_W-1:0] o_r1_res,
    output logic              o_r1_res_valid,
    input  logic              i_r1_res_ready,
    output logic [DATA_W-1:0] o_m_data,
    output logic              o_m_valid,
    input  logic              i_m_ready,
    input  logic [DATA_W-1:0] i_m_res,
    input  logic              i_m_res_valid,
    output logic              o_m_res_ready,
    output logic              o_err
`ifdef MULT_ARB_STATS_EN
    ,
    output logic [15:0]       o_r0_grants,
    output logic [15:0]       o_r1_grants
`endif
);

    localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic                 ptr_q, ptr_d;
    logic [TAG_DEPTH-1:0] tag_q, tag_d;
    logic [PTR_W-1:0]     wr_q, wr_d;
    logic [PTR_W-1:0]     rd_q, rd_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 err_q, err_d;

    logic grant_valid;
    logic grant_idx;
    logic tag_full;
    logic tag_empty;
    logic head;
    logic issue;
    logic pop;

    always_comb begin
        grant_valid = i_r0_valid | i_r1_valid;
        if (ptr_q == 1'b0) begin
            grant_idx = i_r0_valid ? 1'b0 : 1'b1;
        end else begin
            grant_idx = i_r1_valid ? 1'b1 : 1'b0;
        end

        tag_full  = (cnt_q == CNT_W'(TAG_DEPTH));
        tag_empty = (cnt_q == '0);
        head      = tag_q[rd_q];

        o_m_valid  = grant_valid & ~tag_full;
        o_m_data   = grant_idx ? i_r1_data : i_r0_data;
        o_r0_ready = grant_valid & ~grant_idx & i_m_ready & ~tag_full;
        o_r1_ready = grant_valid &  grant_idx & i_m_ready & ~tag_full;
        issue      = o_m_valid & i_m_ready;

        o_r0_res       = i_m_res;
        o_r1_res       = i_m_res;
        o_r0_res_valid = i_m_res_valid & ~tag_empty & ~head;
        o_r1_res_valid = i_m_res_valid & ~tag_empty &  head;
        o_m_res_ready  = ~tag_empty & (head ? i_r1_res_ready : i_r0_res_ready);
        pop            = i_m_res_valid & o_m_res_ready;

        o_err = err_q;
    end

    always_comb begin
        ptr_d = ptr_q;
        tag_d = tag_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        err_d = err_q | (i_m_res_valid & tag_empty);

        if (issue) begin
            ptr_d       = ~grant_idx;
            tag_d[wr_q] = grant_idx;
            wr_d        = wr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_d = rd_q + PTR_W'(1);
        end
        // Full blocks issue, so push-while-full never reaches this counter.
        case ({issue, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr_q <= 1'b0;
            tag_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            tag_q <= tag_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

`ifdef MULT_ARB_STATS_EN
    logic [15:0] r0_grants_q, r0_grants_d;
    logic [15:0] r1_grants_q, r1_grants_d;

    always_comb begin
        r0_grants_d = r0_grants_q;
        r1_grants_d = r1_grants_q;
        if (issue && !grant_idx && r0_grants_q != '1) begin
            r0_grants_d = r0_grants_q + 16'd1;
        end
        if (issue && grant_idx && r1_grants_q != '1) begin
            r1_grants_d = r1_grants_q + 16'd1;
        end
        o_r0_grants = r0_grants_q;
        o_r1_grants = r1_grants_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r0_grants_q <= '0;
            r1_grants_q <= '0;
        end else begin
            r0_grants_q <= r0_grants_d;
            r1_grants_q <= r1_grants_d;
        end
    end
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed self-checking bench for mult_arbiter: arbitration order, result routing,
// FIFO full/pop interaction, backpressure, error flag and reset.
module tb_mult_arbiter;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] r0_data, r1_data, r0_res, r1_res, m_data, m_res;
    logic          r0_valid, r1_valid, r0_ready, r1_ready;
    logic          r0_res_valid, r1_res_valid, r0_res_ready, r1_res_ready;
    logic          m_valid, m_ready, m_res_valid, m_res_ready, err;
`ifdef MULT_ARB_STATS_EN
    logic [15:0]   r0_grants, r1_grants;
`endif

    int unsigned tests_run = 0;
    int unsigned tests_failed = 0;
    int unsigned r0_got, r1_got;
    logic [DW-1:0] prev_data;
    logic          prev_dest;
    logic          exp_g;

    mult_arbiter #(.DATA_W(DW), .TAG_DEPTH(4)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_r0_data(r0_data), .i_r0_valid(r0_valid), .o_r0_ready(r0_ready),
        .i_r1_data(r1_data), .i_r1_valid(r1_valid), .o_r1_ready(r1_ready),
        .o_r0_res(r0_res), .o_r0_res_valid(r0_res_valid), .i_r0_res_ready(r0_res_ready),
        .o_r1_res(r1_res), .o_r1_res_valid(r1_res_valid), .i_r1_res_ready(r1_res_ready),
        .o_m_data(m_data), .o_m_valid(m_valid), .i_m_ready(m_ready),
        .i_m_res(m_res), .i_m_res_valid(m_res_valid), .o_m_res_ready(m_res_ready),
        .o_err(err)
`ifdef MULT_ARB_STATS_EN
        ,
        .o_r0_grants(r0_grants), .o_r1_grants(r1_grants)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        r0_data = '0; r1_data = '0; r0_valid = 0; r1_valid = 0;
        r0_res_ready = 0; r1_res_ready = 0; m_ready = 0; m_res = '0; m_res_valid = 0;
        tick(); tick();
        check_eq("rst_m_valid", {31'd0, m_valid}, 0);
        check_eq("rst_readies", {30'd0, r0_ready, r1_ready}, 0);
        check_eq("rst_res_valid", {30'd0, r0_res_valid, r1_res_valid}, 0);
        check_eq("rst_m_res_ready", {31'd0, m_res_ready}, 0);
        check_eq("rst_err", {31'd0, err}, 0);
        rst = 1'b0;
        tick();

        // Both valid, results looped back one cycle later.
        r0_got = 0; r1_got = 0; prev_data = '0; prev_dest = 0;
        for (int k = 0; k <= 8; k++) begin
            r0_valid = (k < 8); r1_valid = (k < 8);
            r0_data = 32'h100 + k; r1_data = 32'h200 + k;
            m_ready = 1; r0_res_ready = 1; r1_res_ready = 1;
            m_res_valid = (k > 0); m_res = prev_data;
            #1;
            exp_g = (k % 2 == 1);
            if (k < 8) begin
                check_eq("rr_m_valid", {31'd0, m_valid}, 1);
                check_eq("rr_r0_ready", {31'd0, r0_ready}, {31'd0, ~exp_g});
                check_eq("rr_r1_ready", {31'd0, r1_ready}, {31'd0, exp_g});
                check_eq("rr_m_data", m_data, exp_g ? 32'h200 + k : 32'h100 + k);
            end
            if (k > 0) begin
                check_eq("lb_r0_res_valid", {31'd0, r0_res_valid}, {31'd0, ~prev_dest});
                check_eq("lb_r1_res_valid", {31'd0, r1_res_valid}, {31'd0, prev_dest});
                check_eq("lb_res", prev_dest ? r1_res : r0_res, prev_data);
                check_eq("lb_m_res_ready", {31'd0, m_res_ready}, 1);
                if (r0_res_valid) r0_got++;
                if (r1_res_valid) r1_got++;
            end
            prev_data = exp_g ? 32'h200 + k : 32'h100 + k;
            prev_dest = exp_g;
            tick();
        end
        check_eq("lb_r0_count", r0_got, 4);
        check_eq("lb_r1_count", r1_got, 4);
        r0_valid = 0; r1_valid = 0; m_res_valid = 0;
        #1;
        check_eq("lb_empty_res_ready", {31'd0, m_res_ready}, 0);
        check_eq("lb_err", {31'd0, err}, 0);
        tick();

        // Only r1 valid for three cycles, then r0 must be preferred.
        for (int i = 0; i < 3; i++) begin
            r0_valid = 0; r1_valid = 1; r1_data = 32'h300 + i; m_ready = 1;
            #1;
            check_eq("r1only_r1_ready", {31'd0, r1_ready}, 1);
            check_eq("r1only_r0_ready", {31'd0, r0_ready}, 0);
            check_eq("r1only_m_data", m_data, 32'h300 + i);
            tick();
        end
        r0_valid = 1; r1_valid = 1; r0_data = 32'h400; r1_data = 32'h401; m_ready = 0;
        #1;
        check_eq("pref_r0_m_data", m_data, 32'h400);
        check_eq("pref_r0_stall_ready", {31'd0, r0_ready}, 0);
        tick();
        check_eq("pref_r0_hold", m_data, 32'h400);
        r0_valid = 0; r1_valid = 0;
        for (int i = 0; i < 3; i++) begin
            m_res_valid = 1; m_res = 32'h50 + i;
            #1;
            check_eq("drain_r1_res_valid", {31'd0, r1_res_valid}, 1);
            check_eq("drain_r0_res_valid", {31'd0, r0_res_valid}, 0);
            check_eq("drain_r1_res", r1_res, 32'h50 + i);
            tick();
        end
        m_res_valid = 0;

        // Fill the tag FIFO with no returns.
        r0_valid = 1; r1_valid = 1; r0_data = 32'h600; r1_data = 32'h700; m_ready = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("fill_m_valid", {31'd0, m_valid}, 1);
            check_eq("fill_r0_ready", {31'd0, r0_ready}, (i % 2 == 0) ? 1 : 0);
            tick();
        end
        #1;
        check_eq("full_m_valid", {31'd0, m_valid}, 0);
        check_eq("full_readies", {30'd0, r0_ready, r1_ready}, 0);
        m_res_valid = 1; m_res = 32'h11;
        #1;
        check_eq("full_pop_res_ready", {31'd0, m_res_ready}, 1);
        check_eq("full_pop_r0_res_valid", {31'd0, r0_res_valid}, 1);
        check_eq("full_pop_no_issue", {31'd0, m_valid}, 0);
        tick();
        m_res_valid = 0;
        #1;
        check_eq("after_pop_issue", {31'd0, m_valid}, 1);
        check_eq("after_pop_r0_ready", {31'd0, r0_ready}, 1);
        tick();
        check_eq("refull_m_valid", {31'd0, m_valid}, 0);

        // FIFO now holds r1,r0,r1,r0: pop r1, then backpressure r0.
        r0_valid = 0; r1_valid = 0; m_res_valid = 1; m_res = 32'h22;
        #1;
        check_eq("pop_r1_res_valid", {31'd0, r1_res_valid}, 1);
        tick();
        r0_res_ready = 0; r1_res_ready = 1; m_res = 32'hABCD;
        #1;
        check_eq("bp_m_res_ready", {31'd0, m_res_ready}, 0);
        check_eq("bp_r0_res_valid", {31'd0, r0_res_valid}, 1);
        check_eq("bp_r1_res_valid", {31'd0, r1_res_valid}, 0);
        tick();
        check_eq("bp_held_r0_res_valid", {31'd0, r0_res_valid}, 1);
        check_eq("bp_held_m_res_ready", {31'd0, m_res_ready}, 0);
        r0_res_ready = 1;
        #1;
        check_eq("bp_release_ready", {31'd0, m_res_ready}, 1);
        check_eq("bp_release_res", r0_res, 32'hABCD);
        check_eq("bp_release_r1_valid", {31'd0, r1_res_valid}, 0);
        tick();
        m_res_valid = 0;

        // Reset with two tags in flight, then a stray result.
        rst = 1;
        #1;
        check_eq("midrst_m_res_ready", {31'd0, m_res_ready}, 0);
        check_eq("midrst_err", {31'd0, err}, 0);
        #2;
        rst = 0;
        tick();
        m_res_valid = 1; m_res = 32'h77;
        #1;
        check_eq("stray_m_res_ready", {31'd0, m_res_ready}, 0);
        check_eq("stray_res_valid", {30'd0, r0_res_valid, r1_res_valid}, 0);
        check_eq("stray_err_before", {31'd0, err}, 0);
        tick();
        m_res_valid = 0;
        #1;
        check_eq("err_set", {31'd0, err}, 1);
        tick(); tick();
        check_eq("err_sticky", {31'd0, err}, 1);
        rst = 1;
        #1;
        check_eq("err_cleared", {31'd0, err}, 0);
        rst = 0;
        r0_valid = 1; r1_valid = 1; r0_data = 32'h900; r1_data = 32'h901; m_ready = 0;
        #1;
        check_eq("post_rst_r0_prio", m_data, 32'h900);
        tick();

`ifdef MULT_ARB_STATS_EN
        r1_valid = 0; m_ready = 1; r0_res_ready = 1;
        for (int i = 0; i < 70000; i++) begin
            m_res_valid = (i > 0);
            tick();
        end
        r0_valid = 0;
        tick();
        check_eq("stats_r0_sat", {16'd0, r0_grants}, 32'hFFFF);
        check_eq("stats_r1_zero", {16'd0, r1_grants}, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
